// File: rtl/rst_seq_pkg.sv
// Shared types for the staged reset sequencer: FSM states, reset-cause codes
// and the priority encoder that picks the reported cause.
package rst_seq_pkg;

    localparam int unsigned SYNC_STAGES = 2;

    typedef enum logic [1:0] {
        HOLD  = 2'd0,
        STAGE = 2'd1,
        RUN   = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        POR = 2'b00,
        EXT = 2'b01,
        WDT = 2'b10,
        SW  = 2'b11
    } cause_e;

    // External button outranks the watchdog, which outranks software.
    function automatic cause_e encode_cause(input logic ext_req,
                                            input logic wdt_req,
                                            input logic sw_req);
        cause_e cause;
        if (ext_req)      cause = EXT;
        else if (wdt_req) cause = WDT;
        else if (sw_req)  cause = SW;
        else              cause = POR;
        return cause;
    endfunction

endpackage

// File: rtl/rst_ext_filter.sv
// Synchronizes the asynchronous push-button reset and turns it into a request.
// With RSTSEQ_DEBOUNCE_EN defined the low level must persist DEBOUNCE_CYCLES cycles.
module rst_ext_filter
    import rst_seq_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 8
) (
    input  logic clk_i,
    input  logic rstn_i,
    input  logic ext_rstn_i,
    output logic ext_req
);

    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   ext_sync;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            sync_reg <= '1;
        end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], ext_rstn_i};
        end
    end

    assign ext_sync = sync_reg[SYNC_STAGES-1];

`ifdef RSTSEQ_DEBOUNCE_EN
    localparam int unsigned DEB_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic [DEB_W-1:0] deb_cnt_reg;
    logic [DEB_W-1:0] deb_cnt_next;

    // Any high cycle clears the run of lows; the count saturates at the threshold.
    always_comb begin
        deb_cnt_next = deb_cnt_reg;
        if (ext_sync) begin
            deb_cnt_next = '0;
        end else if (deb_cnt_reg != DEB_W'(DEBOUNCE_CYCLES)) begin
            deb_cnt_next = deb_cnt_reg + DEB_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            deb_cnt_reg <= '0;
        end else begin
            deb_cnt_reg <= deb_cnt_next;
        end
    end

    assign ext_req = ~ext_sync & (deb_cnt_reg == DEB_W'(DEBOUNCE_CYCLES));
`else
    assign ext_req = ~ext_sync;
`endif

endmodule

// File: rtl/reset_sequencer.sv
// Staged reset generator: holds every domain in reset, then releases them in
// index order. Optional ext-button debounce is enabled by RSTSEQ_DEBOUNCE_EN.
module reset_sequencer
    import rst_seq_pkg::*;
#(
    parameter int unsigned N_DOMAINS       = 3,
    parameter int unsigned HOLD_CYCLES     = 16,
    parameter int unsigned STAGE_CYCLES    = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 8
) (
    input  logic                 clk_i,
    input  logic                 rstn_i,
    input  logic                 ext_rstn_i,
    input  logic                 wdt_expire_i,
    input  logic                 sw_rst_req_i,
    output logic [N_DOMAINS-1:0] rstn_o,
    output logic                 busy_o,
    output logic                 seq_done_o,
    output logic [1:0]           rst_cause_o
);

    localparam int unsigned CNT_MAX = (HOLD_CYCLES > STAGE_CYCLES) ? HOLD_CYCLES : STAGE_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam int unsigned IDX_W   = (N_DOMAINS > 1) ? $clog2(N_DOMAINS) : 1;

    logic                 ext_req;
    logic                 rst_req;

    state_e               state_reg, state_next;
    logic [CNT_W-1:0]     cnt_reg, cnt_next, cnt_inc;
    logic [IDX_W-1:0]     idx_reg, idx_next;
    logic [N_DOMAINS-1:0] rstn_reg, rstn_next, release_mask;
    logic                 busy_reg, busy_next;
    logic                 done_reg, done_next;
    cause_e               cause_reg, cause_next;

    rst_ext_filter #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_ext_filter (
        .clk_i      (clk_i),
        .rstn_i     (rstn_i),
        .ext_rstn_i (ext_rstn_i),
        .ext_req    (ext_req)
    );

    assign rst_req = ext_req | wdt_expire_i | sw_rst_req_i;
    assign cnt_inc = (cnt_reg == CNT_W'(CNT_MAX)) ? cnt_reg : cnt_reg + CNT_W'(1);

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        idx_next     = idx_reg;
        busy_next    = busy_reg;
        done_next    = 1'b0;
        cause_next   = cause_reg;
        release_mask = '0;

        if (rst_req) begin
            state_next = HOLD;
            cnt_next   = '0;
            idx_next   = '0;
            busy_next  = 1'b1;
            cause_next = encode_cause(ext_req, wdt_expire_i, sw_rst_req_i);
        end else begin
            case (state_reg)
                HOLD: begin
                    if (cnt_reg == CNT_W'(HOLD_CYCLES - 1)) begin
                        release_mask[0] = 1'b1;
                        cnt_next        = '0;
                        if (N_DOMAINS == 1) begin
                            state_next = RUN;
                            busy_next  = 1'b0;
                            done_next  = 1'b1;
                        end else begin
                            state_next = STAGE;
                            idx_next   = IDX_W'(1);
                        end
                    end else begin
                        cnt_next = cnt_inc;
                    end
                end
                STAGE: begin
                    if (cnt_reg == CNT_W'(STAGE_CYCLES - 1)) begin
                        release_mask = N_DOMAINS'(1) << idx_reg;
                        cnt_next     = '0;
                        if (idx_reg == IDX_W'(N_DOMAINS - 1)) begin
                            state_next = RUN;
                            busy_next  = 1'b0;
                            done_next  = 1'b1;
                        end else begin
                            idx_next = idx_reg + IDX_W'(1);
                        end
                    end else begin
                        cnt_next = cnt_inc;
                    end
                end
                RUN: begin
                end
                default: begin
                    state_next = HOLD;
                    cnt_next   = '0;
                end
            endcase
        end
    end

    // A bit only rises once its own release slot arrives, so released bits stay a prefix.
    for (genvar gi = 0; gi < N_DOMAINS; gi++) begin : g_domain
        assign rstn_next[gi] = ~rst_req & (rstn_reg[gi] | release_mask[gi]);
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_reg <= HOLD;
            cnt_reg   <= '0;
            idx_reg   <= '0;
            rstn_reg  <= '0;
            busy_reg  <= 1'b1;
            done_reg  <= 1'b0;
            cause_reg <= POR;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            idx_reg   <= idx_next;
            rstn_reg  <= rstn_next;
            busy_reg  <= busy_next;
            done_reg  <= done_next;
            cause_reg <= cause_next;
        end
    end

    assign rstn_o      = rstn_reg;
    assign busy_o      = busy_reg;
    assign seq_done_o  = done_reg;
    assign rst_cause_o = cause_reg;

endmodule
